// File: rtl/bcd_scan_counter.sv
// NDIG-digit BCD up/down event counter feeding a time-multiplexed 7-segment display scan.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits during the scan).
module bcd_scan_counter #(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NDIG-1:0]       load_val,
    input  logic                    cnt_en,
    input  logic                    cnt_up,
    output logic [4*NDIG-1:0]       count,
    output logic                    wrap,
    output logic [3:0]              digit_bcd,
    output logic [NDIG-1:0]         digit_sel,
    output logic [$clog2(NDIG)-1:0] digit_idx
);

    localparam int IW = $clog2(NDIG);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [4*NDIG-1:0] count_nxt;
    logic              wrap_nxt;
    logic [PW-1:0]     prescaler;
    logic [3:0]        cur_nibble;
    logic              blank;

    function automatic logic [4*NDIG-1:0] bcd_inc(input logic [4*NDIG-1:0] v);
        logic [4*NDIG-1:0] r;
        logic              carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [4*NDIG-1:0] bcd_dec(input logic [4*NDIG-1:0] v);
        logic [4*NDIG-1:0] r;
        logic              borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic all_digits(input logic [4*NDIG-1:0] v, input logic [3:0] d);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] != d) r = 1'b0;
        end
        return r;
    endfunction

    // Out-of-range load nibbles saturate to 9 so the count always stays valid BCD.
    function automatic logic [4*NDIG-1:0] clamp_bcd(input logic [4*NDIG-1:0] v);
        logic [4*NDIG-1:0] r;
        r = v;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (clr) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt = clamp_bcd(load_val);
        end else if (cnt_en) begin
            if (cnt_up) begin
                count_nxt = bcd_inc(count);
                wrap_nxt  = all_digits(count, 4'd9);
            end else begin
                count_nxt = bcd_dec(count);
                wrap_nxt  = all_digits(count, 4'd0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // Scan position is independent of clr/load; only the prescaler moves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_comb begin
        cur_nibble = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (int'(digit_idx) == i) cur_nibble = count[4*i +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this digit and every more significant digit is zero; digit 0 always shows.
    always_comb begin
        blank = (digit_idx != '0);
        for (int i = 0; i < NDIG; i++) begin
            if (i >= int'(digit_idx) && count[4*i +: 4] != 4'd0) blank = 1'b0;
        end
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_bcd <= 4'd0;
            digit_sel <= '1;
        end else begin
            digit_bcd <= cur_nibble;
            digit_sel <= blank ? '1 : ~(NDIG'(1) << digit_idx);
        end
    end

endmodule
